// File: rtl/alu_result_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_stage_pkg
// Description : Shared widths, flag-bit indices and opcode codes for the ALU
//               result/writeback stage.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_result_stage_pkg;

    localparam int c_arg_width = 2;
    localparam int c_sel_width = 5;
    localparam int c_flags_w   = 4;

    // Flag vector layout is {E,V,C,Z}
    localparam int c_flg_z = 0;
    localparam int c_flg_c = 1;
    localparam int c_flg_v = 2;
    localparam int c_flg_e = 3;

    typedef enum logic [c_sel_width-1:0] {
        OP_ADD = 5'd0,
        OP_SUB = 5'd1,
        OP_AND = 5'd2,
        OP_OR  = 5'd3,
        OP_XOR = 5'd4,
        OP_ROL = 5'd5,
        OP_ROR = 5'd6
    } alu_op_e;

    function automatic logic [c_flags_w-1:0] pack_flags(
        input logic e,
        input logic v,
        input logic c,
        input logic z
    );
        logic [c_flags_w-1:0] f;
        f          = '0;
        f[c_flg_e] = e;
        f[c_flg_v] = v;
        f[c_flg_c] = c;
        f[c_flg_z] = z;
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_res_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alu_res_fifo
// Description : Generic DEPTH x WIDTH synchronous FIFO. Pushes when full and
//               pops when empty are ignored; rdata holds the last popped word
//               while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_res_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [WIDTH-1:0]   r_hold;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == c_cnt_w'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = push & ~w_full;
    assign w_pop   = pop & ~w_empty;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_mem
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_mem[i] <= '0;
                end else if (w_push && (r_wr_ptr == c_ptr_w'(i))) begin
                    r_mem[i] <= wdata;
                end
            end
        end
    endgenerate

    // Pointers are power-of-two wide, so natural overflow gives the modulo wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_hold   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_hold   <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rdata = w_empty ? r_hold : r_mem[r_rd_ptr];
    assign empty = w_empty;
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_stage
// Description : Registered writeback stage behind the ALU: buffers result,
//               opcode and {E,V,C,Z} flags in a FIFO, keeps the flags of the
//               last accepted op and a sticky error bit. Optional saturating
//               op/error counters are enabled by ALU_RESULT_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter int DATA_W = c_arg_width,
    parameter int SEL_W  = c_sel_width,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_result,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic                 in_zero,
    input  logic                 in_carry,
    input  logic                 in_overflow,
    input  logic                 in_error,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_result,
    output logic [SEL_W-1:0]     out_sel,
    output logic [c_flags_w-1:0] out_flags,
    output logic [c_flags_w-1:0] flags_q,
    output logic                 err_sticky,
    input  logic                 err_clr,
    output logic [CNT_W-1:0]     op_count,
    output logic [CNT_W-1:0]     err_count
);

    localparam int c_word_w = SEL_W + c_flags_w + DATA_W;
    localparam int c_cnt_w  = $clog2(DEPTH) + 1;

    logic [c_flags_w-1:0] w_in_flags;
    logic [c_word_w-1:0]  w_in_word;
    logic [c_word_w-1:0]  w_out_word;
    logic                 w_empty;
    logic [c_cnt_w-1:0]   w_count;
    logic                 w_accept;
    logic                 w_pop;

    logic [c_flags_w-1:0] r_flags_q;
    logic                 r_err_sticky;

    // Ready comes from the registered occupancy only, so out_ready never
    // reaches in_ready combinationally; a full FIFO never passes through.
    assign in_ready  = (w_count != c_cnt_w'(DEPTH));
    assign out_valid = ~w_empty;
    assign w_accept  = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    assign w_in_flags = pack_flags(in_error, in_overflow, in_carry, in_zero);
    assign w_in_word  = {in_sel, w_in_flags, in_result};

    alu_res_fifo #(
        .WIDTH (c_word_w),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_accept),
        .pop   (w_pop),
        .wdata (w_in_word),
        .rdata (w_out_word),
        .empty (w_empty),
        .count (w_count)
    );

    assign out_result = w_out_word[DATA_W-1:0];
    assign out_flags  = w_out_word[DATA_W +: c_flags_w];
    assign out_sel    = w_out_word[DATA_W + c_flags_w +: SEL_W];

    // A new error in the same cycle as err_clr wins over the clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags_q    <= '0;
            r_err_sticky <= 1'b0;
        end else begin
            if (w_accept) begin
                r_flags_q <= w_in_flags;
            end
            r_err_sticky <= (r_err_sticky & ~err_clr) | (w_accept & in_error);
        end
    end

    assign flags_q    = r_flags_q;
    assign err_sticky = r_err_sticky;

`ifdef ALU_RESULT_PERF_CNT_EN
    logic [CNT_W-1:0] r_op_count;
    logic [CNT_W-1:0] r_err_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_count  <= '0;
            r_err_count <= '0;
        end else if (w_accept) begin
            if (r_op_count != '1) begin
                r_op_count <= r_op_count + 1'b1;
            end
            if (in_error && (r_err_count != '1)) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end
    end

    assign op_count  = r_op_count;
    assign err_count = r_err_count;
`else
    assign op_count  = '0;
    assign err_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_result_stage
// Description : Directed bench for alu_result_stage with a queue scoreboard
//               of accepted entries, compared as they leave the stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_result_stage;
    import alu_result_stage_pkg::*;

    localparam int DATA_W = 2;
    localparam int SEL_W  = 5;
    localparam int DEPTH  = 2;
    localparam int CNT_W  = 4;
    localparam int WORD_W = SEL_W + 4 + DATA_W;

`ifdef ALU_RESULT_PERF_CNT_EN
    localparam int EXP_OPS  = 15;
    localparam int EXP_ERRS = 3;
`else
    localparam int EXP_OPS  = 0;
    localparam int EXP_ERRS = 0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic [SEL_W-1:0]  in_sel;
    logic              in_zero;
    logic              in_carry;
    logic              in_overflow;
    logic              in_error;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [SEL_W-1:0]  out_sel;
    logic [3:0]        out_flags;
    logic [3:0]        flags_q;
    logic              err_sticky;
    logic              err_clr;
    logic [CNT_W-1:0]  op_count;
    logic [CNT_W-1:0]  err_count;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [WORD_W-1:0] sb[$];

    always #5 clk = ~clk;

    alu_result_stage #(
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_result   (in_result),
        .in_sel      (in_sel),
        .in_zero     (in_zero),
        .in_carry    (in_carry),
        .in_overflow (in_overflow),
        .in_error    (in_error),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_sel     (out_sel),
        .out_flags   (out_flags),
        .flags_q     (flags_q),
        .err_sticky  (err_sticky),
        .err_clr     (err_clr),
        .op_count    (op_count),
        .err_count   (err_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        n_total++;
        n_fail++;
        $error("FAIL %s: observed=timeout expected=progress", tag);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [DATA_W-1:0] res, input logic [SEL_W-1:0] sel,
                         input logic [3:0] fl);
        in_valid  = 1'b1;
        in_result = res;
        in_sel    = sel;
        {in_error, in_overflow, in_carry, in_zero} = fl;
    endtask

    // Hold one entry on the input until it is taken, then drop in_valid
    task automatic send(input logic [DATA_W-1:0] res, input logic [SEL_W-1:0] sel,
                        input logic [3:0] fl);
        bit ok = 1'b0;
        drive(res, sel, fl);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        tick(1);
        in_valid = 1'b0;
        if (!ok) fail_now("send_accept");
    endtask

    task automatic drain();
        for (int k = 0; k < 50; k++) begin
            if (sb.size() == 0) break;
            tick(1);
        end
        chk("drain_empty", sb.size(), 0);
        tick(1);
        chk("drain_out_valid", out_valid, 0);
    endtask

    // Scoreboard: record each handshake the next edge will complete
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_total++;
                    n_fail++;
                    $error("FAIL unexpected_pop: observed=%0h expected=none",
                           {out_sel, out_flags, out_result});
                end else begin
                    chk("pop_word", {out_sel, out_flags, out_result}, sb.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back({in_sel, in_error, in_overflow, in_carry, in_zero, in_result});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=no finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
        in_result = '0; in_sel = '0;
        {in_error, in_overflow, in_carry, in_zero} = 4'b0000;
        tick(2);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_word", {out_sel, out_flags, out_result}, 0);
        chk("rst_flags_q", flags_q, 0);
        chk("rst_err_sticky", err_sticky, 0);
        chk("rst_op_count", op_count, 0);
        rst = 1'b0;
        tick(1);

        // Single ADD, appears next cycle
        out_ready = 1'b1;
        drive(2'b00, OP_ADD, 4'b0011);
        tick(1);
        in_valid = 1'b0;
        chk("t1_out_valid", out_valid, 1);
        chk("t1_out_result", out_result, 2'b00);
        chk("t1_out_flags", out_flags, 4'b0011);
        chk("t1_flags_q", flags_q, 4'b0011);
        drain();

        // Back-pressure: fill, third entry waits for a free slot
        out_ready = 1'b0;
        send(2'b01, OP_SUB, 4'b0010);
        send(2'b10, OP_AND, 4'b0100);
        chk("t2_full_ready", in_ready, 0);
        chk("t2_head_result", out_result, 2'b01);
        fork
            send(2'b11, OP_XOR, 4'b0001);
            begin
                tick(2);
                chk("t2_held_ready", in_ready, 0);
                chk("t2_head_sel", out_sel, OP_SUB);
                out_ready = 1'b1;
            end
        join
        chk("t2_flags_q", flags_q, 4'b0001);
        drain();

        // Steady push+pop at occupancy 1
        out_ready = 1'b0;
        send(2'b10, OP_OR, 4'b0000);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(DATA_W'(i), SEL_W'(i + 8), 4'(i));
            @(negedge clk);
            chk("t3_in_ready", in_ready, 1);
            chk("t3_out_valid", out_valid, 1);
            tick(1);
        end
        in_valid = 1'b0;
        chk("t3_flags_q", flags_q, 4'h7);
        drain();

        // Error set wins over a same-cycle clear
        chk("t4_pre_sticky", err_sticky, 0);
        drive(2'b01, OP_ROL, 4'b1000);
        err_clr = 1'b1;
        tick(1);
        in_valid = 1'b0;
        chk("t4_set_wins", err_sticky, 1);
        chk("t4_flags_q", flags_q, 4'b1000);
        tick(1);
        chk("t4_cleared", err_sticky, 0);
        err_clr = 1'b0;
        drain();

        // Reset with two entries buffered
        out_ready = 1'b0;
        send(2'b10, OP_ROR, 4'b0100);
        send(2'b11, OP_ADD, 4'b1010);
        chk("t5_pre_valid", out_valid, 1);
        chk("t5_pre_ready", in_ready, 0);
        chk("t5_pre_sticky", err_sticky, 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t5_out_valid", out_valid, 0);
        chk("t5_in_ready", in_ready, 1);
        chk("t5_flags_q", flags_q, 0);
        chk("t5_err_sticky", err_sticky, 0);
        chk("t5_op_count", op_count, 0);
        chk("t5_out_result", out_result, 0);

        // 17 accepts, 3 with error; 4-bit op counter saturates
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(DATA_W'(i), OP_ADD, (i == 2 || i == 7 || i == 11) ? 4'b1000 : 4'b0001);
            tick(1);
        end
        in_valid = 1'b0;
        drain();
        chk("t6_op_count", op_count, EXP_OPS);
        chk("t6_err_count", err_count, EXP_ERRS);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("t6_sticky_clr", err_sticky, 0);
        chk("t6_op_after_clr", op_count, EXP_OPS);
        chk("t6_err_after_clr", err_count, EXP_ERRS);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
